pour_timer: RTL and testbench

Dose timer for the alcohol dispenser. It watches the four pump-enable lines driven by the pump latch stage and decides when a pour is complete. It then raises the matching stop strobe (`out_ctrl0..3`), which the pump latch stage uses to clear every pump. It sits directly upstream of the pump latch stage and closes the loop: switch → pump on → timed dose → stop strobe → pump off.

---
 rtl/pour_timer.sv | 197 +++++++++++++++++++
 tb/tb_pour_timer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pour_timer.sv
// pour_timer: dose timer for the alcohol dispenser.
// Watches the four pump enables, times a pour on the lowest-index active
// pump and raises the matching stop strobe when the dose has elapsed.
// Optional feature: define POUR_COUNT_EN to add the saturating pour_count
// output (completed pours, aborts excluded).
module pour_timer #(
   parameter int TICK_DIV   = 500000,
   parameter int DOSE_SMALL = 150,
   parameter int DOSE_LARGE = 300,
   parameter int STOP_HOLD  = 4
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        pump1,
   input  logic        pump2,
   input  logic        pump3,
   input  logic        pump4,
   input  logic        size_sel,
   output logic        out_ctrl0,
   output logic        out_ctrl1,
   output logic        out_ctrl2,
   output logic        out_ctrl3,
   output logic        busy,
   output logic        done,
   output logic        abort,
   output logic [15:0] remain
`ifdef POUR_COUNT_EN
   ,
   output logic [7:0]  pour_count
`endif
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (STOP_HOLD > 1) ? $clog2(STOP_HOLD) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(STOP_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

   // Dose lengths are truncated to the 16-bit remain width, then 0 becomes 1.
   localparam logic [15:0] SMALL_TRUNC = 16'(DOSE_SMALL);
   localparam logic [15:0] LARGE_TRUNC = 16'(DOSE_LARGE);
   localparam logic [15:0] SMALL_EFF   = (SMALL_TRUNC == 16'd0) ? 16'd1 : SMALL_TRUNC;
   localparam logic [15:0] LARGE_EFF   = (LARGE_TRUNC == 16'd0) ? 16'd1 : LARGE_TRUNC;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_POUR     = 2'd1,
      ST_STOP     = 2'd2,
      ST_WAIT_LOW = 2'd3
   } state_t;

   // Lowest-index set bit of a pump vector (caller guarantees non-zero).
   function automatic logic [1:0] lowest_active(input logic [3:0] v);
      logic [1:0] idx;
      if (v[0]) begin
         idx = 2'd0;
      end else if (v[1]) begin
         idx = 2'd1;
      end else if (v[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   logic [3:0]    pump_s;
   logic [3:0]    sync1_r;
   logic [3:0]    ps_r;
   state_t        state_r;
   logic [1:0]    ch_r;
   logic [PW-1:0] presc_r;
   logic [HW-1:0] hold_r;
   logic [3:0]    out_ctrl_r;
   logic          busy_r;
   logic          done_r;
   logic          abort_r;
   logic [15:0]   remain_r;

   assign pump_s = {pump4, pump3, pump2, pump1};

   // Two-flop synchroniser for the asynchronous pump enables.
   always_ff @(posedge clk) begin
      if (RESET) begin
         sync1_r <= 4'b0000;
         ps_r    <= 4'b0000;
      end else begin
         sync1_r <= pump_s;
         ps_r    <= sync1_r;
      end
   end

   // Pour state machine with all outputs registered.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_r    <= ST_IDLE;
         ch_r       <= 2'd0;
         presc_r    <= '0;
         hold_r     <= '0;
         out_ctrl_r <= 4'b0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         abort_r    <= 1'b0;
         remain_r   <= 16'd0;
      end else begin
         done_r  <= 1'b0;
         abort_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (ps_r != 4'b0000) begin
                  ch_r     <= lowest_active(ps_r);
                  remain_r <= size_sel ? LARGE_EFF : SMALL_EFF;
                  presc_r  <= '0;
                  busy_r   <= 1'b1;
                  state_r  <= ST_POUR;
               end else begin
                  busy_r   <= 1'b0;
               end
            end
            ST_POUR: begin
               // Losing the timed pump wins over a coincident final tick.
               if (!ps_r[ch_r]) begin
                  abort_r  <= 1'b1;
                  remain_r <= 16'd0;
                  presc_r  <= '0;
                  busy_r   <= 1'b0;
                  state_r  <= ST_IDLE;
               end else if (presc_r == PRESC_LAST) begin
                  presc_r <= '0;
                  if (remain_r == 16'd1) begin
                     remain_r   <= 16'd0;
                     out_ctrl_r <= 4'b0001 << ch_r;
                     done_r     <= 1'b1;
                     hold_r     <= '0;
                     state_r    <= ST_STOP;
                  end else begin
                     remain_r   <= remain_r - 16'd1;
                  end
               end else begin
                  presc_r <= presc_r + PRESC_ONE;
               end
            end
            ST_STOP: begin
               if (hold_r == HOLD_LAST) begin
                  out_ctrl_r <= 4'b0000;
                  state_r    <= ST_WAIT_LOW;
               end else begin
                  hold_r     <= hold_r + HOLD_ONE;
               end
            end
            ST_WAIT_LOW: begin
               // Hold off a retrigger until every pump has been cleared.
               if (ps_r == 4'b0000) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               out_ctrl_r <= 4'b0000;
               busy_r     <= 1'b0;
               remain_r   <= 16'd0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef POUR_COUNT_EN
   logic [7:0] count_r;

   // Count completed pours, saturating at 255.
   always_ff @(posedge clk) begin
      if (RESET) begin
         count_r <= 8'd0;
      end else if (done_r && (count_r != 8'd255)) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign pour_count = count_r;
`endif

   assign out_ctrl0 = out_ctrl_r[0];
   assign out_ctrl1 = out_ctrl_r[1];
   assign out_ctrl2 = out_ctrl_r[2];
   assign out_ctrl3 = out_ctrl_r[3];
   assign busy      = busy_r;
   assign done      = done_r;
   assign abort     = abort_r;
   assign remain    = remain_r;

endmodule

// File: tb/tb_pour_timer.sv
// Self-checking bench for pour_timer: directed and randomized pours compared
// each cycle against a timing model derived from the pour rules.
module tb_pour_timer;

   localparam int TD = 4;
   localparam int DS = 3;
   localparam int DL = 5;
   localparam int SH = 2;

   logic        clk = 1'b0;
   logic        RESET;
   logic [3:0]  pumps_v;
   logic        size_sel;
   logic        oc0, oc1, oc2, oc3;
   logic        busy, done, abort;
   logic [15:0] remain;
   int          n_checks = 0;
   int          n_fail = 0;
`ifdef POUR_COUNT_EN
   logic [7:0]  pour_count;
   int          exp_count = 0;
`endif

   always #5 clk = ~clk;

   pour_timer #(
      .TICK_DIV(TD), .DOSE_SMALL(DS), .DOSE_LARGE(DL), .STOP_HOLD(SH)
   ) dut (
      .clk(clk), .RESET(RESET),
      .pump1(pumps_v[0]), .pump2(pumps_v[1]), .pump3(pumps_v[2]), .pump4(pumps_v[3]),
      .size_sel(size_sel),
      .out_ctrl0(oc0), .out_ctrl1(oc1), .out_ctrl2(oc2), .out_ctrl3(oc3),
      .busy(busy), .done(done), .abort(abort), .remain(remain)
`ifdef POUR_COUNT_EN
      , .pour_count(pour_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {busy, done, abort, out_ctrl[3:0], remain[15:0]}
   function automatic logic [31:0] pack(input logic b, input logic d, input logic a,
                                        input logic [3:0] o, input int r);
      logic [15:0] r16;
      r16 = r[15:0];
      return {9'd0, b, d, a, o, r16};
   endfunction

   function automatic logic [31:0] observed();
      return pack(busy, done, abort, {oc3, oc2, oc1, oc0}, int'(remain));
   endfunction

   // One pour: abort_a >= 0 drops every pump that many cycles after POUR entry;
   // otherwise the timed pump drops at rc and the other pumps at ro.
   task automatic run_pour(input logic [3:0] set, input logic sz, input int abort_a,
                           input int rc, input int ro, input string tag);
      int ch, dose, p, a_edge, s_end, exit_t, t;
      logic others;
      logic [3:0] oh;
      logic [31:0] exp;
      ch = 0;
      for (int i = 3; i >= 0; i--) if (set[i]) ch = i;
      oh = 4'b0001 << ch;
      others = (set & ~oh) != 4'b0000;
      dose = sz ? DL : DS;
      p = dose * TD;
      a_edge = abort_a + 3;
      s_end = p + SH;
      if (abort_a >= 0) begin
         exit_t = a_edge;
      end else begin
         exit_t = s_end + 1;
         if (rc + 3 > exit_t) exit_t = rc + 3;
         if (others && (ro + 3 > exit_t)) exit_t = ro + 3;
      end
      @(posedge clk); #1;
      size_sel = sz;
      pumps_v = set;
      for (int e = 1; e <= exit_t + 5; e++) begin
         @(posedge clk); #1;
         t = e - 3;
         if (t >= 0) size_sel = 1'($urandom_range(0, 1));
         if (abort_a >= 0) begin
            if (t == abort_a) pumps_v = 4'b0000;
         end else begin
            if (t == rc) pumps_v[ch] = 1'b0;
            if (t == ro) pumps_v = pumps_v & oh;
         end
         @(negedge clk);
         if (t < 0)                      exp = pack(1'b0, 1'b0, 1'b0, 4'b0000, 0);
         else if (abort_a >= 0) begin
            if (t < a_edge)              exp = pack(1'b1, 1'b0, 1'b0, 4'b0000, dose - t / TD);
            else if (t == a_edge)        exp = pack(1'b0, 1'b0, 1'b1, 4'b0000, 0);
            else                         exp = pack(1'b0, 1'b0, 1'b0, 4'b0000, 0);
         end
         else if (t < p)                 exp = pack(1'b1, 1'b0, 1'b0, 4'b0000, dose - t / TD);
         else if (t < s_end)             exp = pack(1'b1, t == p, 1'b0, oh, 0);
         else if (t < exit_t)            exp = pack(1'b1, 1'b0, 1'b0, 4'b0000, 0);
         else                            exp = pack(1'b0, 1'b0, 1'b0, 4'b0000, 0);
         check_eq(tag, observed(), exp);
      end
      pumps_v = 4'b0000;
`ifdef POUR_COUNT_EN
      if (abort_a < 0 && exp_count < 255) exp_count++;
      check_eq({tag, "_count"}, 32'(pour_count), 32'(exp_count));
`endif
   endtask

   // Reset asserted during the first strobe cycle, then a normal pour.
   task automatic reset_mid_strobe();
      int p;
      p = DS * TD;
      @(posedge clk); #1;
      size_sel = 1'b0;
      pumps_v = 4'b0010;
      for (int e = 1; e <= 3 + p; e++) @(posedge clk);
      #1;
      RESET = 1'b1;
      pumps_v = 4'b0000;
      @(negedge clk);
      check_eq("strobe_before_reset", observed(), pack(1'b1, 1'b1, 1'b0, 4'b0010, 0));
      @(posedge clk); #1;
      RESET = 1'b0;
      @(negedge clk);
      check_eq("reset_mid_strobe", observed(), pack(1'b0, 1'b0, 1'b0, 4'b0000, 0));
`ifdef POUR_COUNT_EN
      exp_count = 0;
      check_eq("reset_count", 32'(pour_count), 32'(exp_count));
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("idle_after_reset", observed(), pack(1'b0, 1'b0, 1'b0, 4'b0000, 0));
      end
      run_pour(4'b0100, 1'b0, -1, p, 0, "pour_after_reset");
   endtask

   initial begin
      int sz_p, dose, p, abort_a, rc, ro;
      logic [3:0] set;
      logic sz;
      RESET = 1'b1;
      pumps_v = 4'b0000;
      size_sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_state", observed(), pack(1'b0, 1'b0, 1'b0, 4'b0000, 0));
`ifdef POUR_COUNT_EN
      check_eq("reset_count", 32'(pour_count), 32'd0);
`endif
      @(posedge clk); #1;
      RESET = 1'b0;

      // Directed cases.
      run_pour(4'b0010, 1'b0, -1, DS * TD + SH, 0, "small_pump2");
      run_pour(4'b1000, 1'b1, -1, DL * TD, 0, "large_pump4");
      run_pour(4'b0101, 1'b0, -1, DS * TD, DS * TD + SH + 6, "prio_hold_pump3");
      run_pour(4'b0010, 1'b0, 5, 0, 0, "abort_pump2");
      run_pour(4'b0001, 1'b0, DS * TD - 3, 0, 0, "abort_tie_tick");
      run_pour(4'b1111, 1'b1, -1, DL * TD - 2, DL * TD + SH + 1, "all_pumps");
      reset_mid_strobe();

      // Randomized pours.
      for (int i = 0; i < 40; i++) begin
         set = 4'($urandom_range(1, 15));
         sz = 1'($urandom_range(0, 1));
         dose = sz ? DL : DS;
         p = dose * TD;
         sz_p = $urandom_range(0, 2);
         abort_a = (sz_p == 0) ? $urandom_range(0, p - 3) : -1;
         rc = $urandom_range(p - 2, p + SH + 5);
         ro = $urandom_range(0, p + SH + 8);
         run_pour(set, sz, abort_a, rc, ro, "random_pour");
      end

`ifdef POUR_COUNT_EN
      for (int i = 0; i < 256; i++) run_pour(4'b0001, 1'b0, -1, DS * TD - 2, 0, "sat_pour");
      check_eq("count_saturated", 32'(pour_count), 32'd255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
